// File: rtl/rv_mem_pkg.sv
// Shared RV32I memory-stage encodings, FSM state type and data-bus payload.
// Used by the MEM stage, the MEM/WB register and the decoder.
package rv_mem_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  localparam logic [2:0] LD_NONE = 3'b000;
  localparam logic [2:0] LD_LB   = 3'b001;
  localparam logic [2:0] LD_LH   = 3'b010;
  localparam logic [2:0] LD_LW   = 3'b011;
  localparam logic [2:0] LD_LBU  = 3'b100;
  localparam logic [2:0] LD_LHU  = 3'b101;

  localparam logic [1:0] SD_NONE = 2'b00;
  localparam logic [1:0] SD_SB   = 2'b01;
  localparam logic [1:0] SD_SH   = 2'b10;
  localparam logic [1:0] SD_SW   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_e;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [BE_W-1:0] we;
    logic [XLEN-1:0] wdata;
  } dm_bus_t;

  // A nonzero store field overrides whatever the load field holds.
  function automatic acc_size_e access_size(input logic [2:0] ld, input logic [1:0] st);
    acc_size_e sz;
    sz = SZ_WORD;
    if (st != SD_NONE) begin
      case (st)
        SD_SB:   sz = SZ_BYTE;
        SD_SH:   sz = SZ_HALF;
        SD_SW:   sz = SZ_WORD;
        default: sz = SZ_WORD;
      endcase
    end else begin
      case (ld)
        LD_LB, LD_LBU: sz = SZ_BYTE;
        LD_LH, LD_LHU: sz = SZ_HALF;
        LD_LW:         sz = SZ_WORD;
        default:       sz = SZ_WORD;
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: byte enables, replicated store data,
// misalignment detection and read-data lane shift.
module mem_lane_align
  import rv_mem_pkg::*;
(
  input  logic [2:0]      is_load_i,
  input  logic [1:0]      is_store_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      rd_off_i,
  output dm_bus_t         bus_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] rdata_o
);

  acc_size_e  size;
  logic       is_store;
  logic [1:0] off;

  assign size     = access_size(is_load_i, is_store_i);
  assign is_store = (is_store_i != SD_NONE);
  assign off      = addr_i[1:0];

  always_comb begin
    misalign_o  = 1'b0;
    bus_o.addr  = {addr_i[XLEN-1:2], 2'b00};
    bus_o.we    = '0;
    bus_o.wdata = rs2_i;
    case (size)
      SZ_BYTE: begin
        bus_o.wdata = {4{rs2_i[7:0]}};
        if (is_store) bus_o.we = BE_W'(4'b0001 << off);
      end
      SZ_HALF: begin
        misalign_o  = off[0];
        bus_o.wdata = {2{rs2_i[15:0]}};
        if (is_store) bus_o.we = BE_W'(4'b0011 << off);
      end
      default: begin
        misalign_o = (off != 2'b00);
        if (is_store) bus_o.we = '1;
      end
    endcase
  end

  assign rdata_o = rdata_i >> {rd_off_i, 3'b000};

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: turns load/store requests into
// req/ack bus transactions, stalls the pipeline and flags errors.
module mem_access_unit
  import rv_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      is_load_mem,
  input  logic [1:0]      is_store_mem,
  input  logic [XLEN-1:0] alu_out_mem,
  input  logic [XLEN-1:0] rs2_data_mem,
  output logic            dm_req,
  output logic [XLEN-1:0] dm_addr,
  output logic [BE_W-1:0] dm_we,
  output logic [XLEN-1:0] dm_wdata,
  input  logic [XLEN-1:0] dm_rdata,
  input  logic            dm_ack,
  output logic [XLEN-1:0] DM_OUT,
  output logic            stall_mem,
  output logic            misalign_err,
  output logic            bus_err
);

  localparam int unsigned      CNT_W      = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  mem_state_e      state_q, state_d;
  dm_bus_t         bus_q, bus_d, bus_new;
  logic            dm_req_q, dm_req_d;
  logic [XLEN-1:0] dm_out_q, dm_out_d, rdata_shift;
  logic            is_load_q, is_load_d;
  logic [1:0]      off_q, off_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            misalign_q, misalign_d;
  logic            bus_err_q, bus_err_d;
  logic            op_valid, is_store, misalign, timeout_hit;

  mem_lane_align u_lane (
    .is_load_i  (is_load_mem),
    .is_store_i (is_store_mem),
    .addr_i     (alu_out_mem),
    .rs2_i      (rs2_data_mem),
    .rdata_i    (dm_rdata),
    .rd_off_i   (off_q),
    .bus_o      (bus_new),
    .misalign_o (misalign),
    .rdata_o    (rdata_shift)
  );

  assign is_store    = (is_store_mem != SD_NONE);
  assign op_valid    = (is_load_mem != LD_NONE) || is_store;
  assign timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (op_valid && !misalign) state_d = S_REQ;
      S_REQ:   if (dm_ack || timeout_hit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Register next-values and the combinational stall; ack beats timeout in REQ.
  always_comb begin
    bus_d      = bus_q;
    dm_req_d   = dm_req_q;
    dm_out_d   = dm_out_q;
    is_load_d  = is_load_q;
    off_d      = off_q;
    cnt_d      = cnt_q;
    misalign_d = 1'b0;
    bus_err_d  = 1'b0;
    stall_mem  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (op_valid && misalign) begin
          misalign_d = 1'b1;
          dm_out_d   = '0;
        end else if (op_valid) begin
          stall_mem = 1'b1;
          bus_d     = bus_new;
          dm_req_d  = 1'b1;
          is_load_d = !is_store;
          off_d     = alu_out_mem[1:0];
          cnt_d     = '0;
        end
      end
      S_REQ: begin
        stall_mem = 1'b1;
        if (dm_ack) begin
          dm_out_d = is_load_q ? rdata_shift : '0;
          dm_req_d = 1'b0;
        end else if (timeout_hit) begin
          dm_out_d  = '0;
          dm_req_d  = 1'b0;
          bus_err_d = 1'b1;
        end else if (!(&cnt_q)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_q      <= '0;
      dm_req_q   <= 1'b0;
      dm_out_q   <= '0;
      is_load_q  <= 1'b0;
      off_q      <= '0;
      cnt_q      <= '0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      bus_q      <= bus_d;
      dm_req_q   <= dm_req_d;
      dm_out_q   <= dm_out_d;
      is_load_q  <= is_load_d;
      off_q      <= off_d;
      cnt_q      <= cnt_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign dm_req       = dm_req_q;
  assign dm_addr      = bus_q.addr;
  assign dm_we        = bus_q.we;
  assign dm_wdata     = bus_q.wdata;
  assign DM_OUT       = dm_out_q;
  assign misalign_err = misalign_q;
  assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: default-timeout instance for normal
// traffic and a TIMEOUT_CYCLES=4 instance for the timeout boundary.
module tb_mem_access_unit;

  logic        clk, rst;
  logic [2:0]  ld, ld4;
  logic [1:0]  st, st4;
  logic [31:0] addr, rs2, rdata, addr4, rs2_4, rdata4;
  logic        ack, ack4;
  logic        dm_req, stall, mis, berr, dm_req4, stall4, mis4, berr4;
  logic [31:0] dm_addr, dm_wdata, dout, dm_addr4, dm_wdata4, dout4;
  logic [3:0]  dm_we, dm_we4;

  int pass_cnt = 0;
  int total    = 0;

  mem_access_unit u_dut (
    .clk(clk), .rst(rst), .is_load_mem(ld), .is_store_mem(st), .alu_out_mem(addr),
    .rs2_data_mem(rs2), .dm_req(dm_req), .dm_addr(dm_addr), .dm_we(dm_we),
    .dm_wdata(dm_wdata), .dm_rdata(rdata), .dm_ack(ack), .DM_OUT(dout),
    .stall_mem(stall), .misalign_err(mis), .bus_err(berr)
  );

  mem_access_unit #(.TIMEOUT_CYCLES(4)) u_dut4 (
    .clk(clk), .rst(rst), .is_load_mem(ld4), .is_store_mem(st4), .alu_out_mem(addr4),
    .rs2_data_mem(rs2_4), .dm_req(dm_req4), .dm_addr(dm_addr4), .dm_we(dm_we4),
    .dm_wdata(dm_wdata4), .dm_rdata(rdata4), .dm_ack(ack4), .DM_OUT(dout4),
    .stall_mem(stall4), .misalign_err(mis4), .bus_err(berr4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Present an op, ack after `waits` REQ cycles; returns in the DONE cycle.
  task automatic drive_txn(input logic [2:0] l, input logic [1:0] s, input logic [31:0] a,
                           input logic [31:0] d, input int waits, input logic [31:0] rd,
                           output int stalls, output bit stable, output logic [31:0] a_seen,
                           output logic [3:0] we_seen, output logic [31:0] wd_seen);
    int reqc;
    bit first;
    stalls = 0; reqc = 0; first = 1'b1; stable = 1'b1;
    a_seen = '0; we_seen = '0; wd_seen = '0;
    @(negedge clk);
    ld = l; st = s; addr = a; rs2 = d; ack = 1'b0; rdata = '0;
    for (int c = 0; c < 64; c++) begin
      #1;
      if (!stall) break;
      stalls++;
      if (dm_req) begin
        if (first) begin
          a_seen = dm_addr; we_seen = dm_we; wd_seen = dm_wdata; first = 1'b0;
        end else if (dm_addr !== a_seen || dm_we !== we_seen || dm_wdata !== wd_seen) begin
          stable = 1'b0;
        end
        if (reqc == waits) begin ack = 1'b1; rdata = rd; end
        reqc++;
      end else if (stalls > 1) begin
        stable = 1'b0;
      end
      @(negedge clk);
      ack = 1'b0; rdata = '0;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    ld = '0; st = '0; addr = '0; rs2 = '0; ack = 1'b0; rdata = '0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ld = '0; st = '0; addr = '0; rs2 = '0; ack = 1'b0; rdata = '0;
    ld4 = '0; st4 = '0; addr4 = '0; rs2_4 = '0; ack4 = 1'b0; rdata4 = '0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (dm_req !== 1'b0) $display("FAIL reset_req got %b exp 0", dm_req); else pass_cnt++;
    total++; if ({dm_addr, dm_wdata, dm_we} !== 68'h0) $display("FAIL reset_bus got %h/%h/%h exp 0", dm_addr, dm_wdata, dm_we); else pass_cnt++;
    total++; if (dout !== 32'h0) $display("FAIL reset_dmout got %h exp 0", dout); else pass_cnt++;
    total++; if ({mis, berr, stall} !== 3'b000) $display("FAIL reset_flags got %b exp 000", {mis, berr, stall}); else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_load_word();
    int n; bit stb; logic [31:0] a_s, wd_s; logic [3:0] we_s;
    drive_txn(3'b011, 2'b00, 32'h100, 32'h0, 0, 32'hDEADBEEF, n, stb, a_s, we_s, wd_s);
    total++; if (n !== 2) $display("FAIL lw_stall got %0d exp 2", n); else pass_cnt++;
    total++; if (a_s !== 32'h100 || we_s !== 4'h0) $display("FAIL lw_bus got %h/%h exp 100/0", a_s, we_s); else pass_cnt++;
    total++; if (dout !== 32'hDEADBEEF) $display("FAIL lw_dmout got %h exp deadbeef", dout); else pass_cnt++;
    total++; if (dm_req !== 1'b0) $display("FAIL lw_req_drop got %b exp 0", dm_req); else pass_cnt++;
    idle();
  endtask

  task automatic test_load_wait();
    int n; bit stb; logic [31:0] a_s, wd_s; logic [3:0] we_s;
    drive_txn(3'b001, 2'b00, 32'h103, 32'h0, 3, 32'h80112233, n, stb, a_s, we_s, wd_s);
    total++; if (n !== 5) $display("FAIL lb_stall got %0d exp 5", n); else pass_cnt++;
    total++; if (stb !== 1'b1) $display("FAIL lb_stable got %b exp 1", stb); else pass_cnt++;
    total++; if (a_s !== 32'h100) $display("FAIL lb_addr got %h exp 100", a_s); else pass_cnt++;
    total++; if (dout !== 32'h00000080) $display("FAIL lb_dmout got %h exp 00000080", dout); else pass_cnt++;
    idle();
    drive_txn(3'b010, 2'b00, 32'h102, 32'h0, 2, 32'h11223344, n, stb, a_s, we_s, wd_s);
    total++; if (n !== 4) $display("FAIL lh_stall got %0d exp 4", n); else pass_cnt++;
    total++; if (dout !== 32'h00001122) $display("FAIL lh_dmout got %h exp 00001122", dout); else pass_cnt++;
    idle();
  endtask

  task automatic test_stores();
    int n; bit stb; logic [31:0] a_s, wd_s; logic [3:0] we_s;
    drive_txn(3'b000, 2'b10, 32'h202, 32'h0000ABCD, 0, 32'h0, n, stb, a_s, we_s, wd_s);
    total++; if (we_s !== 4'b1100 || wd_s !== 32'hABCDABCD) $display("FAIL sh_bus got %b/%h exp 1100/abcdabcd", we_s, wd_s); else pass_cnt++;
    total++; if (a_s !== 32'h200) $display("FAIL sh_addr got %h exp 200", a_s); else pass_cnt++;
    total++; if (dout !== 32'h0) $display("FAIL sh_dmout got %h exp 0", dout); else pass_cnt++;
    idle();
    drive_txn(3'b000, 2'b01, 32'h301, 32'h12345678, 1, 32'h0, n, stb, a_s, we_s, wd_s);
    total++; if (we_s !== 4'b0010 || wd_s !== 32'h78787878) $display("FAIL sb_bus got %b/%h exp 0010/78787878", we_s, wd_s); else pass_cnt++;
    idle();
    drive_txn(3'b000, 2'b11, 32'h400, 32'hCAFEF00D, 0, 32'h0, n, stb, a_s, we_s, wd_s);
    total++; if (we_s !== 4'hF || wd_s !== 32'hCAFEF00D || a_s !== 32'h400) $display("FAIL sw_bus got %b/%h/%h exp 1111/cafef00d/400", we_s, wd_s, a_s); else pass_cnt++;
    idle();
  endtask

  task automatic test_store_wins();
    int n; bit stb; logic [31:0] a_s, wd_s; logic [3:0] we_s;
    drive_txn(3'b011, 2'b01, 32'h303, 32'h000000A5, 0, 32'h77777777, n, stb, a_s, we_s, wd_s);
    total++; if (n !== 2) $display("FAIL sw_wins_stall got %0d exp 2", n); else pass_cnt++;
    total++; if (we_s !== 4'b1000 || wd_s !== 32'hA5A5A5A5) $display("FAIL sw_wins_bus got %b/%h exp 1000/a5a5a5a5", we_s, wd_s); else pass_cnt++;
    total++; if (dout !== 32'h0) $display("FAIL sw_wins_dmout got %h exp 0", dout); else pass_cnt++;
    idle();
  endtask

  task automatic test_misalign();
    int n; bit stb; logic [31:0] a_s, wd_s; logic [3:0] we_s;
    drive_txn(3'b000, 2'b00, 32'h0, 32'h0, 0, 32'hABCD1234, n, stb, a_s, we_s, wd_s);
    idle();
    drive_txn(3'b011, 2'b00, 32'h101, 32'h0, 0, 32'h0, n, stb, a_s, we_s, wd_s);
    total++; if (n !== 0 || dm_req !== 1'b0) $display("FAIL mis_lw_noreq got stall %0d req %b exp 0/0", n, dm_req); else pass_cnt++;
    idle();
    total++; if (mis !== 1'b1) $display("FAIL mis_lw_pulse got %b exp 1", mis); else pass_cnt++;
    total++; if (dm_req !== 1'b0 || dout !== 32'h0) $display("FAIL mis_lw_state got %b/%h exp 0/0", dm_req, dout); else pass_cnt++;
    idle();
    total++; if (mis !== 1'b0) $display("FAIL mis_pulse_end got %b exp 0", mis); else pass_cnt++;
    drive_txn(3'b000, 2'b10, 32'h203, 32'h0, 0, 32'h0, n, stb, a_s, we_s, wd_s);
    idle();
    total++; if (mis !== 1'b1 || dm_req !== 1'b0) $display("FAIL mis_sh got %b/%b exp 1/0", mis, dm_req); else pass_cnt++;
    idle();
  endtask

  task automatic test_ack_at_timeout();
    int reqc; bit done;
    reqc = 0; done = 1'b0;
    @(negedge clk);
    ld4 = 3'b011; addr4 = 32'h500; ack4 = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (dm_req4) begin
        if (reqc == 3) begin ack4 = 1'b1; rdata4 = 32'h55AA55AA; done = 1'b1; end
        reqc++;
      end
      @(negedge clk);
      ack4 = 1'b0; rdata4 = '0;
      if (done) break;
    end
    #1;
    total++; if (done !== 1'b1 || reqc !== 4) $display("FAIL ack_last_reqc got %0d exp 4", reqc); else pass_cnt++;
    total++; if (berr4 !== 1'b0) $display("FAIL ack_last_buserr got %b exp 0", berr4); else pass_cnt++;
    total++; if (dout4 !== 32'h55AA55AA) $display("FAIL ack_last_dmout got %h exp 55aa55aa", dout4); else pass_cnt++;
    @(negedge clk);
    ld4 = '0; addr4 = '0;
  endtask

  task automatic test_timeout();
    int reqc; bit seen;
    reqc = 0; seen = 1'b0;
    @(negedge clk);
    ld4 = 3'b011; addr4 = 32'h504; ack4 = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (berr4) begin seen = 1'b1; break; end
      if (dm_req4) reqc++;
      @(negedge clk);
    end
    total++; if (seen !== 1'b1) $display("FAIL to_buserr got %b exp 1", seen); else pass_cnt++;
    total++; if (reqc !== 4) $display("FAIL to_req_cycles got %0d exp 4", reqc); else pass_cnt++;
    total++; if (dm_req4 !== 1'b0 || dout4 !== 32'h0 || stall4 !== 1'b0) $display("FAIL to_done got %b/%h/%b exp 0/0/0", dm_req4, dout4, stall4); else pass_cnt++;
    @(negedge clk);
    ld4 = '0; addr4 = '0;
    #1;
    total++; if (berr4 !== 1'b0 || dm_req4 !== 1'b0) $display("FAIL to_idle got %b/%b exp 0/0", berr4, dm_req4); else pass_cnt++;
  endtask

  task automatic test_reset_mid_req();
    int n; bit stb; logic [31:0] a_s, wd_s; logic [3:0] we_s;
    drive_txn(3'b011, 2'b00, 32'h700, 32'h0, 0, 32'h13572468, n, stb, a_s, we_s, wd_s);
    total++; if (dout !== 32'h13572468) $display("FAIL pre_rst_dmout got %h exp 13572468", dout); else pass_cnt++;
    idle();
    @(negedge clk);
    ld = 3'b011; addr = 32'h600;
    @(negedge clk);
    #1;
    total++; if (dm_req !== 1'b1) $display("FAIL mid_req_active got %b exp 1", dm_req); else pass_cnt++;
    rst = 1'b0; ld = '0; addr = '0;
    #1;
    total++; if (dm_req !== 1'b0 || dm_addr !== 32'h0 || dout !== 32'h0 || stall !== 1'b0) $display("FAIL mid_rst_clear got %b/%h/%h/%b exp 0/0/0/0", dm_req, dm_addr, dout, stall); else pass_cnt++;
    @(negedge clk);
    rst = 1'b1; ack = 1'b1; rdata = 32'hFFFFFFFF;
    @(negedge clk);
    ack = 1'b0; rdata = '0;
    #1;
    total++; if (dm_req !== 1'b0 || dout !== 32'h0 || berr !== 1'b0 || stall !== 1'b0) $display("FAIL late_ack got %b/%h/%b/%b exp 0/0/0/0", dm_req, dout, berr, stall); else pass_cnt++;
    drive_txn(3'b011, 2'b00, 32'h104, 32'h0, 1, 32'h0BADF00D, n, stb, a_s, we_s, wd_s);
    total++; if (n !== 3 || a_s !== 32'h104) $display("FAIL post_rst_lw got %0d/%h exp 3/104", n, a_s); else pass_cnt++;
    total++; if (dout !== 32'h0BADF00D) $display("FAIL post_rst_dmout got %h exp 0badf00d", dout); else pass_cnt++;
    idle();
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_load_wait();
    test_stores();
    test_store_wins();
    test_misalign();
    test_ack_at_timeout();
    test_timeout();
    test_reset_mid_req();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
